// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, error codes, frame constants and timing helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        DATA,
        PARITY,
        ACK,
        WAIT_IDLE
    } state_t;

    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_FRAME = 2'b10;
    localparam logic [1:0] ERR_NOACK = 2'b11;

    localparam int PS2_FRAME_BITS = 11;

    // System clock cycles per microsecond.
    function automatic int cycles_per_us(input int clk_freq_hz);
        return clk_freq_hz / 1_000_000;
    endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Multi-stage synchroniser for one asynchronous PS/2 pad plus a falling-edge pulse.
// Latency: SYNC_STAGES cycles to sync, fall valid in the same cycle sync goes low.
// Backpressure: none; free-running.
module ps2_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stg;
    logic                   prev;

    // Shift the pad value through the synchroniser; idle lines reset high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg  <= '1;
            prev <= 1'b1;
        end else begin
            stg  <= {stg[SYNC_STAGES-2:0], din};
            prev <= stg[SYNC_STAGES-1];
        end
    end

    assign sync = stg[SYNC_STAGES-1];
    assign fall = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter (inhibit, request-to-send, 8 data + odd parity, ACK check).
// Latency: INHIBIT_US of clock-low, then one bit per device clock; done/error is a one-cycle pulse.
// Backpressure: tx_ready only in IDLE; optional auto-resend when PS2_TX_RETRY_EN is defined.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int INHIBIT_US  = 100,
    parameter int START_TO_MS = 15,
    parameter int FRAME_TO_MS = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       PS2_clk_in,
    input  logic       PS2_data_in,
    output logic       PS2_clk_drive_low,
    output logic       PS2_data_drive_low,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] tx_err_code
);

    localparam int CPU       = cycles_per_us(CLK_FREQ_HZ);
    localparam int INH_CYC   = INHIBIT_US * CPU;
    localparam int START_CYC = START_TO_MS * 1000 * CPU;
    localparam int FRAME_CYC = FRAME_TO_MS * 1000 * CPU;
    localparam int MAX_SF    = (START_CYC > FRAME_CYC) ? START_CYC : FRAME_CYC;
    localparam int TMR_MAX   = (MAX_SF > INH_CYC) ? MAX_SF : INH_CYC;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] INH_LAST   = TMR_W'(INH_CYC - 1);
    localparam logic [TMR_W-1:0] START_LAST = TMR_W'(START_CYC - 1);
    localparam logic [TMR_W-1:0] FRAME_LAST = TMR_W'(FRAME_CYC - 1);

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [3:0]       bit_cnt;
    logic [8:0]       frame;
    logic             cur_bit;
    logic             clk_sync, clk_fall, data_sync, data_fall_unused;
    logic             accept, tmr_clr, shift, fail;
    logic [1:0]       fail_code;
`ifdef PS2_TX_RETRY_EN
    logic             retried;
    logic             retry_go;
`endif

    // The receiver-side data edge is not needed by the transmitter.
    ps2_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
        .clk(clk), .rst_n(rst_n), .din(PS2_clk_in), .sync(clk_sync), .fall(clk_fall)
    );
    ps2_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
        .clk(clk), .rst_n(rst_n), .din(PS2_data_in), .sync(data_sync), .fall(data_fall_unused)
    );

    assign tx_ready   = (state == IDLE);
    assign rx_inhibit = (state != IDLE);

    // State, shared phase timer, bit pointer and latched frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tmr     <= '0;
            bit_cnt <= '0;
            frame   <= '0;
            cur_bit <= 1'b1;
`ifdef PS2_TX_RETRY_EN
            retried <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (tmr_clr)
                tmr <= '0;
            else if (state != IDLE)
                tmr <= tmr + 1'b1;
            if (accept)
                frame <= {~^tx_data, tx_data};
            if (state == INHIBIT)
                bit_cnt <= '0;
            else if (shift) begin
                cur_bit <= frame[bit_cnt];
                bit_cnt <= bit_cnt + 4'd1;
            end
`ifdef PS2_TX_RETRY_EN
            if (accept)
                retried <= 1'b0;
            else if (retry_go)
                retried <= 1'b1;
`endif
        end
    end

    // Next state and line/pulse outputs; a failure releases both lines in the same cycle.
    always_comb begin
        state_nxt          = state;
        accept             = 1'b0;
        tmr_clr            = 1'b0;
        shift              = 1'b0;
        fail               = 1'b0;
        fail_code          = 2'b00;
        PS2_clk_drive_low  = 1'b0;
        PS2_data_drive_low = 1'b0;
        tx_done            = 1'b0;
        tx_error           = 1'b0;
        tx_err_code        = 2'b00;
`ifdef PS2_TX_RETRY_EN
        retry_go           = 1'b0;
`endif
        case (state)
            IDLE: if (tx_valid) begin
                accept    = 1'b1;
                tmr_clr   = 1'b1;
                state_nxt = INHIBIT;
            end
            INHIBIT: begin
                PS2_clk_drive_low = 1'b1;
                if (tmr == INH_LAST) begin
                    PS2_data_drive_low = 1'b1;
                    tmr_clr            = 1'b1;
                    state_nxt          = RTS;
                end
            end
            RTS: begin
                PS2_data_drive_low = 1'b1;
                if (clk_fall) begin
                    shift     = 1'b1;
                    tmr_clr   = 1'b1;
                    state_nxt = DATA;
                end else if (tmr == START_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_START;
                end
            end
            DATA: begin
                PS2_data_drive_low = ~cur_bit;
                if (clk_fall) begin
                    shift = 1'b1;
                    if (bit_cnt == 4'd8)
                        state_nxt = PARITY;
                end
            end
            PARITY: begin
                PS2_data_drive_low = ~cur_bit;
                if (clk_fall)
                    state_nxt = ACK;
            end
            ACK: if (clk_fall) begin
                if (data_sync) begin
                    fail      = 1'b1;
                    fail_code = ERR_NOACK;
                end else begin
                    state_nxt = WAIT_IDLE;
                end
            end
            WAIT_IDLE: if (clk_sync && data_sync) begin
                tx_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // The frame timer overrides any progress once the device has started clocking.
        if ((state == DATA || state == PARITY || state == ACK || state == WAIT_IDLE) &&
            tmr == FRAME_LAST) begin
            fail      = 1'b1;
            fail_code = ERR_FRAME;
            tx_done   = 1'b0;
        end

        if (fail) begin
            PS2_clk_drive_low  = 1'b0;
            PS2_data_drive_low = 1'b0;
            shift              = 1'b0;
            state_nxt          = IDLE;
`ifdef PS2_TX_RETRY_EN
            if (fail_code != ERR_FRAME && !retried) begin
                retry_go  = 1'b1;
                tmr_clr   = 1'b1;
                state_nxt = INHIBIT;
            end else begin
                tx_error    = 1'b1;
                tx_err_code = fail_code;
            end
`else
            tx_error    = 1'b1;
            tx_err_code = fail_code;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench: open-drain PS/2 device model clocks frames and captures bits on rising edges.
// Latency: scaled clock (1 cycle per us) so timeouts fit a short run.
// Backpressure: host handshake driven only while tx_ready is high.
module tb_ps2_host_tx;

    localparam int CLK_HZ    = 1_000_000;
    localparam int INH_CYC   = 100;
    localparam int START_CYC = 15 * 1000;
    localparam int FRAME_CYC = 2 * 1000;
    localparam int HALF      = 50;
    localparam int SYNC      = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       PS2_clk_in, PS2_data_in;
    logic       PS2_clk_drive_low, PS2_data_drive_low;
    logic       rx_inhibit, tx_done, tx_error;
    logic [1:0] tx_err_code;
    logic       dev_clk, dev_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int clk_low_run = 0, last_low_run = 0;
    int err_cyc = 0, rts_cyc = 0, first_fall_cyc = 0;
    int d0 = 0, e0 = 0;
    logic [1:0] last_code = 2'b00;
    logic [1:0] lines_at_err = 2'b00;

    always #10 clk = ~clk;

    // Wired-AND open-drain pads.
    assign PS2_clk_in  = dev_clk & ~PS2_clk_drive_low;
    assign PS2_data_in = dev_data & ~PS2_data_drive_low;

    ps2_host_tx #(.CLK_FREQ_HZ(CLK_HZ)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .PS2_clk_in(PS2_clk_in), .PS2_data_in(PS2_data_in),
        .PS2_clk_drive_low(PS2_clk_drive_low), .PS2_data_drive_low(PS2_data_drive_low),
        .rx_inhibit(rx_inhibit), .tx_done(tx_done), .tx_error(tx_error), .tx_err_code(tx_err_code)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and clock-low run length, sampled away from the active edge.
    always @(negedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) begin
            err_cnt      <= err_cnt + 1;
            last_code    <= tx_err_code;
            lines_at_err <= {PS2_clk_drive_low, PS2_data_drive_low};
            err_cyc      <= cyc;
        end
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
        if (PS2_clk_drive_low) clk_low_run <= clk_low_run + 1;
        else if (clk_low_run != 0) begin
            last_low_run <= clk_low_run;
            clk_low_run  <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Frame as seen on the wire, index 0 first: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        check("ready_idle", 32'(tx_ready), 1);
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("inhibit_after_accept", 32'(rx_inhibit), 1);
    endtask

    // Wait for request-to-send: clock released, data held low by the host.
    task automatic wait_rts();
        bit seen = 1'b0;
        for (int t = 0; t < INH_CYC + 500 && !seen; t++) begin
            @(negedge clk);
            if (!PS2_clk_drive_low && PS2_data_drive_low) seen = 1'b1;
        end
        rts_cyc = cyc;
        check("rts_seen", 32'(seen), 1);
        check("busy_not_ready", 32'(tx_ready), 0);
    endtask

    task automatic dev_clocks(input int n, input bit nack, output logic [10:0] bits);
        bits = '1;
        repeat (10) @(negedge clk);
        bits[0] = PS2_data_in;
        for (int k = 1; k <= n; k++) begin
            if (k == 11) dev_data = nack;
            dev_clk = 1'b0;
            if (k == 1) first_fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            if (k <= 10) bits[k] = PS2_data_in;
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_result(input int limit, output int nd, output int ne);
        for (int t = 0; t < limit && done_cnt == d0 && err_cnt == e0; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        nd = done_cnt - d0;
        ne = err_cnt - e0;
    endtask

    task automatic run_ok(input logic [7:0] b, input bit poke);
        logic [10:0] bits;
        int nd, ne;
        send(b);
        wait_rts();
        if (poke) begin
            tx_data  = ~b;
            tx_valid = 1'b1;
            repeat (5) @(negedge clk);
            tx_valid = 1'b0;
        end
        dev_clocks(11, 1'b0, bits);
        check("frame_bits", 32'(bits), 32'(frame_of(b)));
        wait_result(500, nd, ne);
        check("done_once", nd, 1);
        check("no_error", ne, 0);
        check("ready_after", 32'(tx_ready), 1);
    endtask

    initial begin
        logic [10:0] bits;
        logic [7:0]  pat [3];
        logic [2:0]  par_exp;
        int nd, ne, delta;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_lines", 32'({PS2_clk_drive_low, PS2_data_drive_low}), 0);
        check("rst_inhibit", 32'(rx_inhibit), 0);
        check("rst_pulses", 32'({tx_done, tx_error, tx_err_code}), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Set-LEDs command: inhibit length and full frame.
        run_ok(8'hED, 1'b0);
        check("clk_low_len", last_low_run, INH_CYC);
        check("ed_parity", 32'(frame_of(8'hED)), 32'(11'b11_1110_1101_0));

        // Parity corner bytes.
        pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h01;
        par_exp = 3'b011;
        for (int i = 0; i < 3; i++) begin
            send(pat[i]);
            wait_rts();
            dev_clocks(11, 1'b0, bits);
            check("parity_bit", 32'(bits[9]), 32'(par_exp[i]));
            wait_result(500, nd, ne);
            check("parity_done", nd, 1);
        end

        // Random bytes with tx_valid noise while busy.
        for (int i = 0; i < 4; i++) run_ok(8'($urandom_range(0, 255)), 1'b1);

        // Device never clocks: start timeout.
        send(8'h55);
        wait_rts();
`ifdef PS2_TX_RETRY_EN
        wait_result(2 * START_CYC + 1000, nd, ne);
        check("start_to_err", ne, 1);
`else
        wait_result(START_CYC + 1000, nd, ne);
        check("start_to_err", ne, 1);
        delta = err_cyc - rts_cyc;
        check("start_to_len", 32'(delta >= START_CYC - 1 && delta <= START_CYC), 1);
`endif
        check("start_to_code", 32'(last_code), 32'(2'b01));
        check("start_to_lines", 32'(lines_at_err), 0);
        check("start_to_nodone", nd, 0);

        // Device stops after bit 3: frame timeout, never retried.
        send(8'hA5);
        wait_rts();
        dev_clocks(4, 1'b0, bits);
        wait_result(FRAME_CYC + 1000, nd, ne);
        check("frame_to_err", ne, 1);
        check("frame_to_code", 32'(last_code), 32'(2'b10));
        check("frame_to_lines", 32'(lines_at_err), 0);
        delta = err_cyc - first_fall_cyc;
        check("frame_to_len", 32'(delta >= FRAME_CYC && delta <= FRAME_CYC + SYNC + 1), 1);

        // Device leaves data high at the ACK edge.
        send(8'h3C);
        wait_rts();
        dev_clocks(11, 1'b1, bits);
        check("nack_bits", 32'(bits), 32'(frame_of(8'h3C)));
`ifdef PS2_TX_RETRY_EN
        wait_rts();
        dev_clocks(11, 1'b0, bits);
        check("retry_bits", 32'(bits), 32'(frame_of(8'h3C)));
        wait_result(500, nd, ne);
        check("retry_done", nd, 1);
        check("retry_no_err", ne, 0);
`else
        wait_result(500, nd, ne);
        check("nack_err", ne, 1);
        check("nack_code", 32'(last_code), 32'(2'b11));
        check("nack_nodone", nd, 0);
`endif

        // Reset in the middle of DATA.
        send(8'h12);
        wait_rts();
        dev_clocks(3, 1'b0, bits);
        check("pre_rst_data_low", 32'(PS2_data_drive_low), 1);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_lines", 32'({PS2_clk_drive_low, PS2_data_drive_low}), 0);
        check("mid_rst_ready", 32'({tx_ready, rx_inhibit}), 32'(2'b10));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        run_ok(8'hF4, 1'b0);

        check("done_error_exclusive", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
